// File: rtl/mac_array_pkg.sv
// mac_array_pkg: shared widths, MNT field positions, FSM state encoding and the
// dimension clamp used when the host's M/N/T fields are latched.
package mac_array_pkg;

  localparam int DW  = 8;   // input/weight element width
  localparam int OW  = 16;  // output element width
  localparam int DIM = 8;   // max M/N/T, also lanes per dot product

  // MNT field positions: [11:8]=M, [7:4]=N, [3:0]=T
  localparam int MNT_M_LSB = 8;
  localparam int MNT_N_LSB = 4;
  localparam int MNT_T_LSB = 0;
  localparam int MNT_FW    = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_ROW,
    ST_RD_I,
    ST_CAP_I,
    ST_MAC,
    ST_WR_LO,
    ST_WR_HI,
    ST_ZW_LO,
    ST_ZW_HI,
    ST_DONE
  } state_e;

  // Latched run dimensions, each already clamped to 1..DIM
  typedef struct packed {
    logic [MNT_FW-1:0] m;
    logic [MNT_FW-1:0] n;
    logic [MNT_FW-1:0] t;
  } dims_t;

  // 0 means 1, anything above DIM means DIM
  function automatic logic [MNT_FW-1:0] clamp_dim(input logic [MNT_FW-1:0] f);
    if (f == '0)                return MNT_FW'(1);
    else if (f > MNT_FW'(DIM))  return MNT_FW'(DIM);
    else                        return f;
  endfunction

endpackage

// File: rtl/mac_array_dot8.sv
// mac_dot8: combinational signed dot product over NUM_LANES lanes.
//   a_vec, b_vec : packed element vectors, element 0 in the top byte
//   n_len        : number of active lanes (1..NUM_LANES); higher lanes ignored
//   col_en       : forces the result to 0 for unused output columns
//   dot          : full-precision sum truncated to OW bits (two's-complement wrap)
module mac_dot8
  import mac_array_pkg::*;
#(
  parameter int NUM_LANES = DIM,
  parameter int VEC_W     = DW
) (
  input  logic [NUM_LANES-1:0][VEC_W-1:0] a_vec,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] b_vec,
  input  logic [MNT_FW-1:0]               n_len,
  input  logic                            col_en,
  output logic [OW-1:0]                   dot
);

  // one guard bit above the worst-case growth so -128*-128*8 stays positive
  localparam int PW    = 2 * VEC_W;
  localparam int SUM_W = PW + $clog2(NUM_LANES) + 1;

  logic [NUM_LANES-1:0][PW-1:0] prod;
  logic signed [SUM_W-1:0]      acc;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic signed [PW-1:0] p;
    // element i lives in packed index NUM_LANES-1-i (top byte first)
    assign p       = $signed(a_vec[NUM_LANES-1-i]) * $signed(b_vec[NUM_LANES-1-i]);
    assign prod[i] = (32'(n_len) > i) ? p : '0;
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      acc = acc + SUM_W'($signed(prod[i]));
    end
  end

  assign dot = col_en ? acc[OW-1:0] : '0;

endmodule

// File: rtl/mac_array.sv
// mac_array: OUT(TxM) = IN(TxN) * W(NxM), signed 8-bit elements, 16-bit wrapped
// results. Weights (transposed) are preloaded into a register bank, then each of
// 8 output rows is either computed (t<T) or zero-filled (t>=T), two 64-bit
// output words per row, addresses 0..15 in order.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   MNT, START         dimensions (latched on START acceptance), level start
//   EN_W/ADDR_W/RDATA_W  weight-transpose SRAM read port (row m = column m)
//   EN_I/ADDR_I/RDATA_I  input SRAM read port (row t)
//   EN_O/RW_O/ADDR_O/WDATA_O/RDATA_O  output SRAM, write-only use
module mac_array
  import mac_array_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] MNT,
  input  logic        START,
  output logic        EN_W,
  output logic [2:0]  ADDR_W,
  input  logic [63:0] RDATA_W,
  output logic        EN_I,
  output logic [2:0]  ADDR_I,
  input  logic [63:0] RDATA_I,
  output logic        EN_O,
  output logic        RW_O,
  output logic [3:0]  ADDR_O,
  output logic [63:0] WDATA_O,
  input  logic [63:0] RDATA_O
);

  state_e state_q, state_d;

  dims_t                          dims_q, dims_d;
  logic [MNT_FW-1:0]              wcnt_q, wcnt_d;      // weight read index 0..M
  logic                           wcap_vld_q, wcap_vld_d;
  logic [2:0]                     wcap_row_q, wcap_row_d;
  logic [2:0]                     t_q, t_d;
  logic [DIM-1:0][DIM-1:0][DW-1:0] w_bank_q, w_bank_d;
  logic [DIM-1:0][DW-1:0]         in_q, in_d;
  logic [DIM-1:0][OW-1:0]         res_q, res_d;
  logic [DIM-1:0][OW-1:0]         dot;

  logic unused_rdata_o;
  assign unused_rdata_o = ^RDATA_O;

  // ---------------------------------------------------------------- dot products
  for (genvar m = 0; m < DIM; m++) begin : g_col
    mac_dot8 #(.NUM_LANES(DIM), .VEC_W(DW)) u_dot (
      .a_vec  (in_q),
      .b_vec  (w_bank_q[m]),
      .n_len  (dims_q.n),
      .col_en (32'(dims_q.m) > m),
      .dot    (dot[m])
    );
  end

  // ---------------------------------------------------------------- state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (START) state_d = ST_LOAD_W;
      // one extra cycle after the last read so its data is captured
      ST_LOAD_W: if (wcnt_q == dims_q.m) state_d = ST_ROW;
      ST_ROW:    state_d = ({1'b0, t_q} < dims_q.t) ? ST_RD_I : ST_ZW_LO;
      ST_RD_I:   state_d = ST_CAP_I;
      ST_CAP_I:  state_d = ST_MAC;
      ST_MAC:    state_d = ST_WR_LO;
      ST_WR_LO:  state_d = ST_WR_HI;
      ST_ZW_LO:  state_d = ST_ZW_HI;
      ST_WR_HI,
      ST_ZW_HI:  state_d = (t_q == 3'd7) ? ST_DONE : ST_ROW;
      // START is a level: wait for it to drop so a held START cannot rerun
      ST_DONE:   if (!START) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    EN_W    = 1'b0;
    ADDR_W  = '0;
    EN_I    = 1'b0;
    ADDR_I  = '0;
    EN_O    = 1'b0;
    RW_O    = 1'b0;
    ADDR_O  = '0;
    WDATA_O = '0;
    case (state_q)
      ST_LOAD_W: begin
        if (wcnt_q < dims_q.m) begin
          EN_W   = 1'b1;
          ADDR_W = wcnt_q[2:0];
        end
      end
      ST_RD_I: begin
        EN_I   = 1'b1;
        ADDR_I = t_q;
      end
      ST_WR_LO: begin
        EN_O    = 1'b1;
        RW_O    = 1'b1;
        ADDR_O  = {t_q, 1'b0};
        WDATA_O = {res_q[0], res_q[1], res_q[2], res_q[3]};
      end
      ST_WR_HI: begin
        EN_O    = 1'b1;
        RW_O    = 1'b1;
        ADDR_O  = {t_q, 1'b1};
        WDATA_O = {res_q[4], res_q[5], res_q[6], res_q[7]};
      end
      ST_ZW_LO: begin
        EN_O   = 1'b1;
        RW_O   = 1'b1;
        ADDR_O = {t_q, 1'b0};
      end
      ST_ZW_HI: begin
        EN_O   = 1'b1;
        RW_O   = 1'b1;
        ADDR_O = {t_q, 1'b1};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    dims_d   = dims_q;
    wcnt_d   = wcnt_q;
    t_d      = t_q;
    w_bank_d = w_bank_q;
    in_d     = in_q;
    res_d    = res_q;

    // a weight read issued this cycle lands in the bank at the end of the next
    wcap_vld_d = (state_q == ST_LOAD_W) && (wcnt_q < dims_q.m);
    wcap_row_d = wcnt_q[2:0];
    if (wcap_vld_q) w_bank_d[wcap_row_q] = RDATA_W;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          dims_d.m = clamp_dim(MNT[MNT_M_LSB +: MNT_FW]);
          dims_d.n = clamp_dim(MNT[MNT_N_LSB +: MNT_FW]);
          dims_d.t = clamp_dim(MNT[MNT_T_LSB +: MNT_FW]);
          wcnt_d   = '0;
          t_d      = '0;
          // rows >= M must read as zero, so wipe the bank up front
          w_bank_d = '0;
          in_d     = '0;
          res_d    = '0;
        end
      end
      ST_LOAD_W: if (wcnt_q != dims_q.m) wcnt_d = wcnt_q + 1'b1;
      ST_CAP_I:  in_d  = RDATA_I;
      ST_MAC:    res_d = dot;
      ST_WR_HI,
      ST_ZW_HI:  t_d = t_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dims_q     <= '0;
      wcnt_q     <= '0;
      wcap_vld_q <= 1'b0;
      wcap_row_q <= '0;
      t_q        <= '0;
      w_bank_q   <= '0;
      in_q       <= '0;
      res_q      <= '0;
    end else begin
      dims_q     <= dims_d;
      wcnt_q     <= wcnt_d;
      wcap_vld_q <= wcap_vld_d;
      wcap_row_q <= wcap_row_d;
      t_q        <= t_d;
      w_bank_q   <= w_bank_d;
      in_q       <= in_d;
      res_q      <= res_d;
    end
  end

endmodule

// File: tb/tb_mac_array.sv
module tb_mac_array;
  import mac_array_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [11:0] MNT;
  logic        EN_W, EN_I, EN_O, RW_O;
  logic [2:0]  ADDR_W, ADDR_I;
  logic [3:0]  ADDR_O;
  logic [63:0] RDATA_W, RDATA_I, WDATA_O;
  logic [63:0] RDATA_O = '0;

  always #5 CLK = ~CLK;

  mac_array dut (
    .CLK(CLK), .RST(RST), .MNT(MNT), .START(START),
    .EN_W(EN_W), .ADDR_W(ADDR_W), .RDATA_W(RDATA_W),
    .EN_I(EN_I), .ADDR_I(ADDR_I), .RDATA_I(RDATA_I),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O), .RDATA_O(RDATA_O)
  );

  // synchronous-read SRAM models
  logic [63:0] wmem [8];
  logic [63:0] imem [8];
  always @(posedge CLK) begin
    if (EN_W) RDATA_W <= wmem[ADDR_W];
    if (EN_I) RDATA_I <= imem[ADDR_I];
  end

  typedef struct { logic [3:0] addr; logic [63:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int n_checks = 0, n_pass = 0, n_writes = 0;
  bit          fix_en = 1'b0;
  logic [63:0] fix0, fix1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, got, exp);
  endtask

  // output-SRAM write monitor / scoreboard
  always @(negedge CLK) begin
    if (RST === 1'b0 && EN_O === 1'b1) begin
      n_writes++;
      chk("rw_o", 64'(RW_O), 64'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL extra_write got addr=%0d data=%h want=no write", ADDR_O, WDATA_O);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(ADDR_O), 64'(mon_e.addr));
        chk("wr_data", WDATA_O, mon_e.data);
      end
      if (fix_en && ADDR_O == 4'd0) chk("fixed_word0", WDATA_O, fix0);
      if (fix_en && ADDR_O == 4'd1) chk("fixed_word1", WDATA_O, fix1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int lim(input logic [3:0] f);
    if (f == 4'd0) return 1;
    if (f > 4'd8)  return 8;
    return int'(f);
  endfunction

  task automatic fill(input int pat);
    for (int r = 0; r < 8; r++) begin
      case (pat)
        1: begin
          for (int n = 0; n < 8; n++) begin
            imem[r][63-8*n -: 8] = 8'(r + 1 + n);
            wmem[r][63-8*n -: 8] = (n == r) ? 8'h01 : 8'h00;
          end
        end
        2: begin imem[r] = {8{8'h80}}; wmem[r] = {8{8'h80}}; end
        3: begin imem[r] = {8{8'hFF}}; wmem[r] = {8{8'hFF}}; end
        4, 6: begin
          imem[r] = {$urandom, $urandom};
          wmem[r] = {$urandom, $urandom};
        end
        default: begin imem[r] = {8{8'h01}}; wmem[r] = {8{8'h01}}; end
      endcase
    end
    if (pat == 4) begin
      imem[0][63:56] = 8'h03;
      wmem[0][63:56] = 8'hFE;
    end
  endtask

  // reference matrix multiply producing the 16 expected writes
  task automatic push_exp(input logic [11:0] mnt);
    int mm, nn, tt, m, s;
    logic [63:0] w;
    mm = lim(mnt[11:8]); nn = lim(mnt[7:4]); tt = lim(mnt[3:0]);
    for (int t = 0; t < 8; t++) begin
      for (int h = 0; h < 2; h++) begin
        w = '0;
        for (int c = 0; c < 4; c++) begin
          m = h * 4 + c;
          s = 0;
          if (t < tt && m < mm)
            for (int n = 0; n < nn; n++)
              s += int'($signed(imem[t][63-8*n -: 8])) * int'($signed(wmem[m][63-8*n -: 8]));
          w[63-16*c -: 16] = s[15:0];
        end
        exp_q.push_back('{addr: 4'(2*t + h), data: w});
      end
    end
  endtask

  task automatic wait_run(input string name);
    int cyc = 0;
    while (!(n_writes >= 16 && exp_q.size() == 0) && cyc < 500) begin
      tick();
      cyc++;
    end
    if (cyc >= 500) begin
      n_checks++;
      $display("FAIL %s_timeout got writes=%0d want=16", name, n_writes);
    end
  endtask

  typedef struct {
    logic [11:0] mnt;
    int          pat;
    bit          fixed;
    logic [63:0] e0, e1;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs[0] = '{12'h777, 0, 1'b1, 64'h0007_0007_0007_0007, 64'h0007_0007_0007_0000};
    vecs[1] = '{12'h888, 1, 1'b1, 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008};
    vecs[2] = '{12'h888, 2, 1'b1, 64'h0, 64'h0};
    vecs[3] = '{12'h888, 3, 1'b1, 64'h0008_0008_0008_0008, 64'h0008_0008_0008_0008};
    vecs[4] = '{12'h111, 4, 1'b1, 64'hFFFA_0000_0000_0000, 64'h0};
    vecs[5] = '{12'h0F3, 5, 1'b1, 64'h0008_0000_0000_0000, 64'h0};
    vecs[6] = '{12'h352, 6, 1'b0, 64'h0, 64'h0};
    vecs[7] = '{12'h000, 6, 1'b0, 64'h0, 64'h0};
    vecs[8] = '{12'h9AC, 6, 1'b0, 64'h0, 64'h0};

    RST = 1'b1; START = 1'b0; MNT = '0;
    repeat (3) tick();
    chk("reset_ctrl", 64'({EN_W, ADDR_W, EN_I, ADDR_I, EN_O, RW_O, ADDR_O}), 64'd0);
    chk("reset_wdata", WDATA_O, 64'd0);
    chk("reset_state", 64'(dut.state_q), 64'(ST_IDLE));
    RST = 1'b0;
    tick();

    // table: START held high through each run, no rerun while held
    for (int v = 0; v < 9; v++) begin
      fill(vecs[v].pat);
      push_exp(vecs[v].mnt);
      fix_en = vecs[v].fixed; fix0 = vecs[v].e0; fix1 = vecs[v].e1;
      n_writes = 0;
      MNT = vecs[v].mnt;
      START = 1'b1;
      wait_run($sformatf("vec%0d", v));
      repeat (40) tick();
      chk($sformatf("vec%0d_write_count", v), 64'(n_writes), 64'd16);
      chk($sformatf("vec%0d_done_hold", v), 64'(dut.state_q), 64'(ST_DONE));
      START = 1'b0;
      tick(); tick();
      chk($sformatf("vec%0d_idle", v), 64'(dut.state_q), 64'(ST_IDLE));
    end
    fix_en = 1'b0;

    // reset during row 3 aborts; restart rereads weights from row 0
    begin
      int cyc = 0;
      fill(0);
      push_exp(12'h777);
      n_writes = 0;
      MNT = 12'h777;
      START = 1'b1;
      while (n_writes < 7 && cyc < 300) begin tick(); cyc++; end
      if (cyc >= 300) begin
        n_checks++;
        $display("FAIL rst_trigger_timeout got writes=%0d want=7", n_writes);
      end
      RST = 1'b1;
      exp_q.delete();
      tick();
      chk("rst_abort_en", 64'({EN_W, EN_I, EN_O}), 64'd0);
      chk("rst_abort_state", 64'(dut.state_q), 64'(ST_IDLE));
      push_exp(12'h777);
      n_writes = 0;
      RST = 1'b0;
      tick();
      chk("restart_w_read", 64'({EN_W, ADDR_W}), 64'h8);
      wait_run("restart");
      repeat (20) tick();
      chk("restart_write_count", 64'(n_writes), 64'd16);
      START = 1'b0;
      tick(); tick();
    end

    // single-cycle START pulses, two identical runs
    fill(6);
    MNT = 12'h888;
    for (int p = 0; p < 2; p++) begin
      push_exp(12'h888);
      n_writes = 0;
      START = 1'b1;
      tick();
      START = 1'b0;
      wait_run($sformatf("pulse%0d", p));
      repeat (10) tick();
      chk($sformatf("pulse%0d_write_count", p), 64'(n_writes), 64'd16);
      chk($sformatf("pulse%0d_idle", p), 64'(dut.state_q), 64'(ST_IDLE));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_array.md
Name: mac_array

Overview:
- Matrix-multiply engine that computes OUT(T x M) = IN(T x N) * W(N x M). M, N and T are each 1..8, and every element is signed 8-bit.
- It reads the input matrix and the transposed weight matrix from two external 8-entry x 64-bit synchronous SRAMs.
- It writes 16-bit results to a 16-entry x 64-bit output SRAM.
- Sits between three SRAM macros and a host that supplies dimensions and START.

Parameters:
- DW, 8, input/weight element width (bits)
- OW, 16, output element width (bits)
- DIM, 8, maximum M/N/T

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- MNT  in  12  [11:8]=M, [7:4]=N, [3:0]=T, binary 1..8
- START  in  1  start request (level)
- EN_W  out  1  weight SRAM enable
- ADDR_W  out  3  weight SRAM row (weight-transpose row m = output column m)
- RDATA_W  in  64  weight SRAM read data
- EN_I  out  1  input SRAM enable
- ADDR_I  out  3  input SRAM row t
- RDATA_I  in  64  input SRAM read data
- EN_O  out  1  output SRAM enable
- RW_O  out  1  1=write, 0=read (always 1 when EN_O=1)
- ADDR_O  out  4  output SRAM address
- WDATA_O  out  64  output write data
- RDATA_O  in  64  output SRAM read data, unused

Behaviour:
- Reset: FSM goes to IDLE; all outputs are 0; weight/input/result registers are cleared. Asserting RST mid-operation aborts it immediately; no further SRAM accesses occur.
- SRAM timing: a read issued with EN=1/ADDR at edge k returns RDATA valid after edge k+1 and is captured on edge k+2. A write completes on the edge where EN_O=RW_O=1.
- Data layout: word row r holds element (r,1) in [63:56] ... (r,8) in [7:0]. Output word 2t holds (t,1..4) with (t,1) in [63:48]. Output word 2t+1 holds (t,5..8).
- MNT is latched at START acceptance. A field value of 0 is treated as 1; a value >8 is treated as 8.
- FSM states:
  - IDLE: START=1 -> LOAD_W.
  - LOAD_W: issue weight reads addr 0..M-1 on consecutive cycles; capture each into weight bank row m one cycle after its read; rows >=M are zero. Then go to ROW with t=0.
  - ROW: if t<T, run RD_I -> CAP_I -> MAC -> WR_LO -> WR_HI (1 cycle each); otherwise run ZW_LO -> ZW_HI, writing zeros to 2t/2t+1. t increments after each hi-word write. After t=7 -> DONE.
  - DONE: all enables are 0; stay here while START=1; START=0 -> IDLE. Because START is level-sensitive, holding it high never retriggers a run.
- MAC stage: for each m<M, result[m] = sum over n<N of sext(in[t][n]) * sext(w[m][n]). Elements with n>=N are ignored; result[m]=0 for m>=M. Sums are computed at full precision, then truncated to 16 bits (two's-complement wrap). Results are registered.
- All 16 output addresses are written exactly once per run, in order 0..15. Unused rows and columns are written as 0.
- No output-SRAM reads are ever issued.

Decomposition:
- Shared package: field-slice constants for MNT, FSM state enum, DW/OW/DIM.
- One sub-module, mac_dot8: combinational 8-lane signed dot product with an N mask and 16-bit wrap, instantiated 8 times (one per output column).

Test Plan:
- MNT=12'h777, all inputs and weights 8'h01, START held high:
  - addr 0 = 0007_0007_0007_0007;
  - addr 1 = 0007_0007_0007_0000;
  - addrs 2..13 alternate those two values;
  - addrs 14,15 = 0;
  - exactly 16 writes, no second run.
- MNT=12'h888, W = identity, IN row t = bytes t+1..t+8: output row t equals IN row t sign-extended to 16 bits.
- MNT=12'h888, all elements 8'h80: every output = 8*16384 = 131072 wrapped to 16'h0000. With all 8'hFF: every output = 16'h0008.
- MNT=12'h111, IN(1,1)=8'h03, W(1,1)=8'hFE: addr 0 = FFFA_0000_0000_0000; addrs 1..15 = 0.
- Reset pulse during row 3 of a 777 run: all EN_* drop to 0 on the next edge and the FSM is in IDLE. Releasing reset with START high starts a fresh run that rereads weights from addr 0.
- START pulse 1 cycle, then low: run completes, returns to IDLE. A second pulse produces an identical 16-write sequence.
